// File: rtl/seg_disp_scheduler.sv
// seg_disp_scheduler
// Multiplexes NUM_SRC 32-bit debug words onto the single 7-segment display
// data bus. Valid sources are shown round-robin, each for DWELL_CYCLES clocks.
// A source can also take the display exclusively through a pin request/grant
// handshake; competing pin requests are arbitrated round-robin.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   src_data_i   packed source words, source i at [32*i+31:32*i]
//   src_valid_i  source i takes part in rotation
//   pin_req_i    level-sensitive exclusive display requests
//   pin_gnt_o    registered one-hot pin grant
//   freeze_i     stalls the rotation dwell counter
//   disp_data_o  registered word to display, aligned with disp_sel_o
//   disp_sel_o   registered index of the displayed source
//   disp_blank_o nothing is displayed
//   page_tick_o  one-cycle pulse after every page load
module seg_disp_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 16666667,
    parameter int SEL_W        = $clog2(NUM_SRC),
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC*32-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    input  logic [NUM_SRC-1:0]    pin_req_i,
    output logic [NUM_SRC-1:0]    pin_gnt_o,
    input  logic                  freeze_i,
    output logic [31:0]           disp_data_o,
    output logic [SEL_W-1:0]      disp_sel_o,
    output logic                  disp_blank_o,
    output logic                  page_tick_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_PINNED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(NUM_SRC - 1);
    localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

    // First set bit of vec strictly after index 'from', wrapping; 'from' itself
    // is examined last, so a lone set bit at 'from' returns 'from'.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] vec,
                                                 input logic [SEL_W-1:0]   from);
        logic [SEL_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = from;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(from) + k) % NUM_SRC;
            if (!found && vec[idx]) begin
                pick  = SEL_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [31:0]          data_q, data_d;
    logic [NUM_SRC-1:0]   gnt_q, gnt_d;
    logic                 blank_q, blank_d;
    logic                 tick_q;
    logic                 load_s;
    logic [SEL_W-1:0]     pin_pick_s;
    logic [SEL_W-1:0]     valid_first_s;
    logic [SEL_W-1:0]     valid_next_s;

    // Candidate indices: pin winner from the RR pointer, lowest valid source
    // (search starting just after the top index), next valid after sel.
    assign pin_pick_s    = rr_pick(pin_req_i, ptr_q);
    assign valid_first_s = rr_pick(src_valid_i, SEL_LAST);
    assign valid_next_s  = rr_pick(src_valid_i, sel_q);

    // Next-state logic for mode, displayed index, dwell counter and RR pointer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pin_req_i) begin
                    state_d = ST_PINNED;
                    sel_d   = pin_pick_s;
                    ptr_d   = pin_pick_s;
                    cnt_d   = '0;
                    load_s  = 1'b1;
                end else if (|src_valid_i) begin
                    state_d = ST_ROTATE;
                    sel_d   = valid_first_s;
                    cnt_d   = '0;
                    load_s  = 1'b1;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_ROTATE: begin
                // Pins win over both valid-drop and dwell expiry.
                if (|pin_req_i) begin
                    state_d = ST_PINNED;
                    sel_d   = pin_pick_s;
                    ptr_d   = pin_pick_s;
                    cnt_d   = '0;
                    load_s  = 1'b1;
                end else if (!(|src_valid_i)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!src_valid_i[sel_q]) begin
                    // Valid-drop advance is not held off by freeze.
                    sel_d   = valid_next_s;
                    cnt_d   = '0;
                    load_s  = 1'b1;
                end else if (freeze_i) begin
                    cnt_d   = cnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    sel_d   = valid_next_s;
                    cnt_d   = '0;
                    load_s  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_PINNED: begin
                cnt_d = '0;
                if (pin_req_i[sel_q]) begin
                    sel_d = sel_q;
                end else if (|pin_req_i) begin
                    // Direct handover keeps the grant one-hot throughout.
                    sel_d  = pin_pick_s;
                    ptr_d  = pin_pick_s;
                    load_s = 1'b1;
                end else if (|src_valid_i) begin
                    state_d = ST_ROTATE;
                    sel_d   = valid_next_s;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                cnt_d   = '0;
                ptr_d   = '0;
            end
        endcase
    end

    // Output values derived from the next state so data stays aligned with sel.
    always_comb begin
        data_d  = 32'h0000_0000;
        gnt_d   = '0;
        blank_d = 1'b1;
        if (state_d == ST_IDLE) begin
            data_d  = 32'h0000_0000;
            blank_d = 1'b1;
        end else begin
            data_d  = src_data_i[32*int'(sel_d) +: 32];
            blank_d = 1'b0;
        end
        if (state_d == ST_PINNED) begin
            gnt_d = ONE_HOT0 << sel_d;
        end else begin
            gnt_d = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            data_q  <= 32'h0000_0000;
            gnt_q   <= '0;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            blank_q <= blank_d;
            tick_q  <= load_s;
        end
    end

    assign disp_sel_o   = sel_q;
    assign disp_data_o  = data_q;
    assign pin_gnt_o    = gnt_q;
    assign disp_blank_o = blank_q;
    assign page_tick_o  = tick_q;

endmodule

// File: tb/tb_seg_disp_scheduler.sv
// Bench for seg_disp_scheduler (NUM_SRC=4, DWELL_CYCLES=4): a table of
// per-cycle vectors, hand sequences for freeze / pin handover / long pin hold,
// then random stimulus checked against a behavioural model every cycle.
module tb_seg_disp_scheduler;

    localparam int N = 4;
    localparam int D = 4;

    logic          clk;
    logic          rst_n;
    logic [N*32-1:0] src_data_i;
    logic [N-1:0]  src_valid_i;
    logic [N-1:0]  pin_req_i;
    logic [N-1:0]  pin_gnt_o;
    logic          freeze_i;
    logic [31:0]   disp_data_o;
    logic [1:0]    disp_sel_o;
    logic          disp_blank_o;
    logic          page_tick_o;

    seg_disp_scheduler #(.NUM_SRC(N), .DWELL_CYCLES(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_data_i   (src_data_i),
        .src_valid_i  (src_valid_i),
        .pin_req_i    (pin_req_i),
        .pin_gnt_o    (pin_gnt_o),
        .freeze_i     (freeze_i),
        .disp_data_o  (disp_data_o),
        .disp_sel_o   (disp_sel_o),
        .disp_blank_o (disp_blank_o),
        .page_tick_o  (page_tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 = nothing shown, 1 = rotating, 2 = pinned
    int          m_mode, m_sel, m_age, m_last_gnt;
    bit          m_tick;
    logic [31:0] m_data;

    function automatic int lowest_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int first_after(input logic [N-1:0] v, input int from);
        for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
        return from;
    endfunction

    task automatic grant_pin();
        m_sel      = first_after(pin_req_i, m_last_gnt);
        m_last_gnt = m_sel;
        m_mode     = 2;
        m_age      = 0;
    endtask

    task automatic model_step();
        bit load;
        load = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_sel = 0; m_age = 0; m_last_gnt = 0;
            m_tick = 1'b0; m_data = 32'h0;
        end else begin
            if (m_mode == 0) begin
                if (pin_req_i != 0) begin grant_pin(); load = 1'b1; end
                else if (src_valid_i != 0) begin
                    m_mode = 1; m_sel = lowest_set(src_valid_i); m_age = 0; load = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (pin_req_i != 0) begin grant_pin(); load = 1'b1; end
                else if (src_valid_i == 0) m_mode = 0;
                else if (!src_valid_i[m_sel] || (!freeze_i && m_age == D - 1)) begin
                    m_sel = first_after(src_valid_i, m_sel); m_age = 0; load = 1'b1;
                end else if (!freeze_i) m_age++;
            end else begin
                if (!pin_req_i[m_sel]) begin
                    if (pin_req_i != 0) begin grant_pin(); load = 1'b1; end
                    else if (src_valid_i != 0) begin
                        m_mode = 1; m_sel = first_after(src_valid_i, m_sel); m_age = 0; load = 1'b1;
                    end else m_mode = 0;
                end
            end
            m_tick = load;
            m_data = (m_mode == 0) ? 32'h0 : src_data_i[32*m_sel +: 32];
        end
    endtask

    task automatic model_compare();
        chk("m_blank", {31'd0, disp_blank_o}, {31'd0, (m_mode == 0)});
        chk("m_gnt", {28'd0, pin_gnt_o}, (m_mode == 2) ? (32'd1 << m_sel) : 32'd0);
        chk("m_tick", {31'd0, page_tick_o}, {31'd0, m_tick});
        chk("m_data", disp_data_o, m_data);
        if (m_mode != 0) chk("m_sel", {30'd0, disp_sel_o}, m_sel);
    endtask

    // One clock: model samples the same inputs as the DUT, compare 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        model_compare();
    endtask

    task automatic load_words();
        for (int i = 0; i < N; i++) src_data_i[32*i +: 32] = 32'h1111_1111 * (i + 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pin_req_i = '0; freeze_i = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  pin;
        logic        frz;
        logic [1:0]  sel;
        logic [3:0]  gnt;
        logic        blank;
        logic        tick;
        logic [31:0] data;
    } vec_t;

    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'h2222_2222;
    localparam logic [31:0] W2 = 32'h3333_3333;
    localparam logic [31:0] W3 = 32'h4444_4444;

    vec_t tbl[21];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] p,
                                input logic f, input logic [1:0] s, input logic [3:0] g,
                                input logic b, input logic t, input logic [31:0] d);
        vec_t x;
        x.rst = r; x.valid = v; x.pin = p; x.frz = f;
        x.sel = s; x.gnt = g; x.blank = b; x.tick = t; x.data = d;
        return x;
    endfunction

    int found;
    int cnt1;

    initial begin
        rst_n = 1'b0; src_valid_i = 4'b1111; pin_req_i = '0; freeze_i = 1'b0;
        src_data_i = '0;
        load_words();
        m_mode = 0; m_sel = 0; m_age = 0; m_last_gnt = 0; m_tick = 1'b0; m_data = 32'h0;

        tbl[0]  = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 32'h0);
        tbl[2]  = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, W0);
        tbl[3]  = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, W0);
        tbl[4]  = tbl[3];
        tbl[5]  = tbl[3];
        tbl[6]  = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b1, W1);
        tbl[7]  = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, W1);
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b1, W3);
        tbl[11] = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0, W3);
        tbl[12] = tbl[11];
        tbl[13] = tbl[11];
        tbl[14] = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, W0);
        tbl[15] = mk(1'b1, 4'b1011, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b1, W2);
        tbl[16] = mk(1'b1, 4'b1011, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0, W2);
        tbl[17] = mk(1'b1, 4'b1011, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b1, W3);
        tbl[18] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b1, 1'b0, 32'h0);
        tbl[19] = mk(1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b1, W0);
        tbl[20] = mk(1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 21; i++) begin
            rst_n = tbl[i].rst; src_valid_i = tbl[i].valid;
            pin_req_i = tbl[i].pin; freeze_i = tbl[i].frz;
            cycle();
            chk($sformatf("t%0d_gnt", i), {28'd0, pin_gnt_o}, {28'd0, tbl[i].gnt});
            chk($sformatf("t%0d_blank", i), {31'd0, disp_blank_o}, {31'd0, tbl[i].blank});
            chk($sformatf("t%0d_tick", i), {31'd0, page_tick_o}, {31'd0, tbl[i].tick});
            chk($sformatf("t%0d_data", i), disp_data_o, tbl[i].data);
            if (!tbl[i].blank || !tbl[i].rst)
                chk($sformatf("t%0d_sel", i), {30'd0, disp_sel_o}, {30'd0, tbl[i].sel});
        end

        // Freeze while sel=1: page stays 14 cycles in total.
        do_reset();
        src_valid_i = 4'b1011;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cycle();
            if (!disp_blank_o && disp_sel_o == 2'd1) found = 1;
        end
        chk("frz_reach_sel1", found, 1);
        cnt1 = 1;
        freeze_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (disp_sel_o == 2'd1) cnt1++;
        end
        freeze_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (disp_sel_o != 2'd1) break;
            cnt1++;
        end
        chk("frz_cycles", cnt1, 14);
        chk("frz_next_sel", {30'd0, disp_sel_o}, 32'd3);

        // Valid drop while frozen still advances.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cycle();
            if (disp_sel_o == 2'd1) found = 1;
        end
        chk("drop_reach_sel1", found, 1);
        freeze_i = 1'b1;
        src_valid_i = 4'b1001;
        cycle();
        chk("drop_sel", {30'd0, disp_sel_o}, 32'd3);
        chk("drop_tick", {31'd0, page_tick_o}, 32'd1);
        freeze_i = 1'b0;

        // Pin handover with RR pointer at 0: 1 wins, then moves directly to 3.
        do_reset();
        src_valid_i = 4'b0000;
        pin_req_i = 4'b1010;
        cycle();
        chk("rr_first_gnt", {28'd0, pin_gnt_o}, 32'b0010);
        pin_req_i = 4'b1000;
        cycle();
        chk("rr_handover_gnt", {28'd0, pin_gnt_o}, 32'b1000);
        chk("rr_handover_tick", {31'd0, page_tick_o}, 32'd1);
        chk("rr_handover_sel", {30'd0, disp_sel_o}, 32'd3);
        pin_req_i = 4'b0000;
        cycle();

        // Long pin hold of source 2, release back into rotation at 3.
        do_reset();
        src_valid_i = 4'b1011;
        cycle();
        pin_req_i = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("hold_gnt", {28'd0, pin_gnt_o}, 32'b0100);
            chk("hold_data", disp_data_o, W2);
        end
        pin_req_i = 4'b0000;
        cycle();
        chk("release_sel", {30'd0, disp_sel_o}, 32'd3);
        chk("release_gnt", {28'd0, pin_gnt_o}, 32'd0);

        // Randomised run against the model.
        do_reset();
        for (int i = 0; i < N; i++) src_data_i[32*i +: 32] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) src_valid_i[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 11) == 0) pin_req_i[$urandom_range(0, N-1)] ^= 1'b1;
            freeze_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) src_data_i[32*$urandom_range(0, N-1) +: 32] = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_disp_scheduler.md
Name: seg_disp_scheduler

Overview:
- Time-multiplexes up to NUM_SRC 32-bit debug words onto the single 7-segment display data bus (the m_7segcon sev_seg_disp input).
- Rotates round-robin over the enabled sources with a programmable dwell time.
- Supports pinned (exclusive) display requests through a request/grant handshake, round-robin arbitrated.
- Instantiated in the FPGA build between the mcu_top debug taps and m_7segcon.

Parameters:
- NUM_SRC, 4, number of display sources (2..8).
- DWELL_CYCLES, 16666667, clk cycles each page is shown in rotation (≥2).
- SEL_W, $clog2(NUM_SRC), width of source index (derived).
- CNT_W, $clog2(DWELL_CYCLES), dwell counter width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- src_data_i  in  NUM_SRC*32  packed source words; source i occupies bits [32*i+31:32*i].
- src_valid_i  in  NUM_SRC  source i takes part in rotation.
- pin_req_i  in  NUM_SRC  source i requests exclusive display; level-sensitive, held until released.
- pin_gnt_o  out  NUM_SRC  one-hot pin grant, registered.
- freeze_i  in  1  stalls the rotation dwell counter.
- disp_data_o  out  32  word to display, registered.
- disp_sel_o  out  SEL_W  index of the displayed source, registered.
- disp_blank_o  out  1  no source is displayed.
- page_tick_o  out  1  one-cycle pulse on every page load.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low.
- Reset values: state=IDLE, disp_sel_o=0, disp_data_o=0, disp_blank_o=1, pin_gnt_o=0, page_tick_o=0, dwell counter=0, RR pin pointer=0.
- States: IDLE, ROTATE, PINNED. All transitions take effect on the next clk edge.
- IDLE:
  - Any pin_req_i → PINNED (grant per pin arbitration).
  - Else any src_valid_i → ROTATE with sel = lowest valid index.
  - Else stay in IDLE.
- ROTATE:
  - Counter increments each cycle unless freeze_i=1.
  - When counter==DWELL_CYCLES-1: counter←0, sel ← next valid index above sel, wrapping modulo NUM_SRC. If sel is the only valid source, sel is reloaded with the same value.
  - src_valid_i[sel]=0 forces an immediate advance to the next valid index on the next cycle, counter←0. This applies even when freeze_i=1.
  - No valid source → IDLE.
  - Any pin_req_i → PINNED. Pin requests take priority over dwell expiry and valid-drop events in the same cycle.
- Pin arbitration: round-robin. Search starts at the index after the last granted index (RR pointer); the pointer updates on each grant.
- PINNED:
  - pin_gnt_o = one-hot of the granted index; sel = granted index. Dwell counter is held at 0.
  - src_valid_i and freeze_i are ignored.
  - Holds while pin_req_i[granted]=1.
  - On release: if other pin requests are pending, the grant moves directly to the next RR winner. pin_gnt_o changes one-hot to one-hot with no zero cycle.
  - On release with no other pins: if any source is valid → ROTATE with sel = next valid index after the released index, counter←0, pin_gnt_o←0. Otherwise → IDLE, pin_gnt_o←0.
- Data path:
  - disp_data_o ← src_data_i slice selected by the next-state sel, registered each cycle. disp_data_o therefore tracks live source data with 1-cycle latency and is always aligned with disp_sel_o.
  - In IDLE: disp_data_o=0 and disp_blank_o=1. Otherwise disp_blank_o=0.
- page_tick_o is high for exactly one cycle after any sel load, i.e. entry to ROTATE/PINNED, dwell expiry, valid-drop advance, or grant handover. It is not asserted on the entry to IDLE.
- Reset asserted mid-operation returns all state and outputs to reset values at the next edge.

Test Plan:
Bench settings: NUM_SRC=4, DWELL_CYCLES=4, src word i = 32'h11111111*(i+1).
1. Hold rst_n=0 for 2 cycles with src_valid_i=4'b1111 → disp_blank_o=1, disp_data_o=0, pin_gnt_o=0, disp_sel_o=0 throughout.
2. Set src_valid_i=4'b1011 and release reset → disp_sel_o follows 0,1,3,0,… with each page held 4 cycles. disp_data_o shows 0x11111111, 0x22222222, 0x44444444. page_tick_o pulses once per page change.
3. Hold freeze_i=1 for 10 cycles while sel=1 → sel stays 1 for 14 cycles total. Then clear src_valid_i[1] while still frozen → sel=3 on the next cycle.
4. In ROTATE with sel=0, assert pin_req_i=4'b0100 → next cycle pin_gnt_o=4'b0100, disp_sel_o=2, disp_data_o=0x33333333, held for 20 cycles. Release → ROTATE with sel=3 and pin_gnt_o=0.
5. Assert pin_req_i=4'b1010 simultaneously with RR pointer=0 → pin_gnt_o=4'b0010. Drop pin_req_i[1] → next cycle pin_gnt_o=4'b1000 with no zero-grant cycle, and page_tick_o pulses.
6. Drop src_valid_i to 4'b0000 during ROTATE → next cycle state=IDLE, disp_blank_o=1, disp_data_o=0. Then assert rst_n=0 mid-PINNED → all outputs return to reset values at the next edge.
